// File: rtl/im_filter_ctrl_param.sv
// Control unit for the spatial filter datapath: decodes the tagged input stream, tracks
// input and window-centre positions for a run-time image size, and flushes the frame tail.
module im_filter_ctrl_param #(
    parameter int DATA_BIT      = 15,
    parameter int DATA_IDBIT    = 2,
    parameter int CNT_BIT       = 10,
    parameter int MASK_WIDTH    = 7,
    parameter int CF_IDX_BIT    = 6,
    parameter int MAX_ROW_WIDTH = 640,
    parameter int MAX_COL_WIDTH = 480
) (
    input  logic                  clk,
    input  logic                  reset_in,
    input  logic                  data_in_valid,
    input  logic [DATA_IDBIT-1:0] data_id,
    input  logic [DATA_BIT-1:0]   data_in,
    output logic                  data_in_ready,
    output logic                  ctrl2buf_valid,
    output logic [DATA_BIT-1:0]   data_out,
    output logic                  update_cf,
    output logic [CF_IDX_BIT-1:0] cf_index,
    output logic                  win_valid,
    output logic [CNT_BIT-1:0]    center_row,
    output logic [CNT_BIT-1:0]    center_col,
    output logic [1:0]            border_mode,
    output logic                  busy,
    output logic                  frame_done,
    output logic                  cfg_err
);
    localparam int HALF    = (MASK_WIDTH - 1) / 2;
    localparam int DIM_BIT = CNT_BIT + 1;
    // The flush distance HALF*W+HALF can outgrow CNT_BIT, so push/flush counters get their own width.
    localparam int FL_BIT  = $clog2(HALF * MAX_ROW_WIDTH + HALF + 1);

    localparam logic [DIM_BIT-1:0]    MIN_DIM = DIM_BIT'(MASK_WIDTH);
    localparam logic [DIM_BIT-1:0]    MAX_W   = DIM_BIT'(MAX_ROW_WIDTH);
    localparam logic [DIM_BIT-1:0]    MAX_H   = DIM_BIT'(MAX_COL_WIDTH);
    localparam logic [DIM_BIT-1:0]    ONE_D   = DIM_BIT'(1);
    localparam logic [CNT_BIT-1:0]    ONE_C   = CNT_BIT'(1);
    localparam logic [FL_BIT-1:0]     ONE_F   = FL_BIT'(1);
    localparam logic [FL_BIT-1:0]     HALF_F  = FL_BIT'(HALF);
    localparam logic [CF_IDX_BIT-1:0] CF_LAST = CF_IDX_BIT'(MASK_WIDTH * MASK_WIDTH - 1);
    localparam logic [CF_IDX_BIT-1:0] ONE_CF  = CF_IDX_BIT'(1);
    localparam logic [DATA_IDBIT-1:0] ID_PIX  = DATA_IDBIT'(0);
    localparam logic [DATA_IDBIT-1:0] ID_COEF = DATA_IDBIT'(1);
    localparam logic [DATA_IDBIT-1:0] ID_CFG  = DATA_IDBIT'(2);

    typedef enum logic [1:0] {S_IDLE = 2'd0, S_STREAM = 2'd1, S_FLUSH = 2'd2} state_t;

    state_t                r_state, w_nextState;
    logic [DIM_BIT-1:0]    r_width, r_height;
    logic [CNT_BIT-1:0]    r_inRow, r_inCol, r_cRow, r_cCol;
    logic [FL_BIT-1:0]     r_pushCnt, r_flushCnt;
    logic [CF_IDX_BIT-1:0] r_cfIdx;
    logic                  r_flushLast;

    logic               w_accept, w_pixel, w_flushPush, w_push, w_win;
    logic               w_lastPixel, w_lastPush, w_startFrame;
    logic               w_setW, w_setH, w_setMode, w_cfWrite, w_cfgErr;
    logic               w_inColEnd, w_inRowEnd, w_cColEnd;
    logic [DIM_BIT-1:0] w_cfgVal, w_wMax, w_hMax;
    logic [FL_BIT-1:0]  w_dist;

    assign w_accept   = data_in_valid & data_in_ready;
    assign w_cfgVal   = {1'b0, data_in[CNT_BIT+1:2]} + ONE_D;
    assign w_wMax     = r_width - ONE_D;
    assign w_hMax     = r_height - ONE_D;
    assign w_dist     = HALF_F * FL_BIT'(r_width) + HALF_F;
    assign w_inColEnd = ({1'b0, r_inCol} == w_wMax);
    assign w_inRowEnd = ({1'b0, r_inRow} == w_hMax);
    assign w_cColEnd  = ({1'b0, r_cCol} == w_wMax);
    assign w_push     = w_pixel | w_flushPush;
    assign w_win      = w_push & (r_pushCnt == w_dist);

    always_ff @(posedge clk or posedge reset_in) begin
        if (reset_in) r_state <= S_IDLE;
        else          r_state <= w_nextState;
    end

    always_comb begin
        w_nextState  = r_state;
        w_pixel      = 1'b0;
        w_flushPush  = 1'b0;
        w_lastPixel  = 1'b0;
        w_lastPush   = 1'b0;
        w_startFrame = 1'b0;
        w_setW       = 1'b0;
        w_setH       = 1'b0;
        w_setMode    = 1'b0;
        w_cfWrite    = 1'b0;
        w_cfgErr     = 1'b0;
        case (r_state)
            S_IDLE: begin
                if (w_accept) begin
                    if (data_id == ID_PIX) begin
                        w_pixel      = 1'b1;
                        w_startFrame = 1'b1;
                        w_nextState  = S_STREAM;
                    end else if (data_id == ID_COEF) begin
                        w_cfWrite = 1'b1;
                    end else if (data_id == ID_CFG) begin
                        case (data_in[1:0])
                            2'd0: if (w_cfgVal >= MIN_DIM && w_cfgVal <= MAX_W) w_setW = 1'b1;
                                  else w_cfgErr = 1'b1;
                            2'd1: if (w_cfgVal >= MIN_DIM && w_cfgVal <= MAX_H) w_setH = 1'b1;
                                  else w_cfgErr = 1'b1;
                            2'd2: w_setMode = 1'b1;
                            default: ;
                        endcase
                    end
                end
            end
            S_STREAM: begin
                if (w_accept) begin
                    if (data_id == ID_PIX) begin
                        w_pixel = 1'b1;
                        if (w_inColEnd && w_inRowEnd) begin
                            w_lastPixel = 1'b1;
                            w_nextState = S_FLUSH;
                        end
                    end else if (data_id == ID_COEF || data_id == ID_CFG) begin
                        w_cfgErr = 1'b1;
                    end
                end
            end
            S_FLUSH: begin
                w_flushPush = 1'b1;
                if (r_flushCnt == ONE_F) begin
                    w_lastPush  = 1'b1;
                    w_nextState = S_IDLE;
                end
            end
            default: w_nextState = S_IDLE;
        endcase
    end

    // Registered outputs and configuration; busy stays up through the final flush push.
    always_ff @(posedge clk or posedge reset_in) begin
        if (reset_in) begin
            data_in_ready  <= 1'b1;
            ctrl2buf_valid <= 1'b0;
            data_out       <= '0;
            update_cf      <= 1'b0;
            cf_index       <= '0;
            win_valid      <= 1'b0;
            center_row     <= '0;
            center_col     <= '0;
            busy           <= 1'b0;
            frame_done     <= 1'b0;
            cfg_err        <= 1'b0;
            border_mode    <= 2'd0;
            r_flushLast    <= 1'b0;
            r_width        <= MAX_W;
            r_height       <= MAX_H;
            r_cfIdx        <= '0;
        end else begin
            data_in_ready  <= (w_nextState != S_FLUSH);
            ctrl2buf_valid <= w_push;
            data_out       <= (w_pixel || w_cfWrite) ? data_in : '0;
            update_cf      <= w_cfWrite;
            cf_index       <= w_cfWrite ? r_cfIdx : '0;
            win_valid      <= w_win;
            center_row     <= w_win ? r_cRow : '0;
            center_col     <= w_win ? r_cCol : '0;
            busy           <= (w_nextState != S_IDLE) || (r_state == S_FLUSH);
            r_flushLast    <= w_lastPush;
            frame_done     <= r_flushLast;
            cfg_err        <= w_cfgErr;
            if (w_setW)    r_width <= w_cfgVal;
            if (w_setH)    r_height <= w_cfgVal;
            if (w_setMode) border_mode <= (data_in[3:2] == 2'd3) ? 2'd0 : data_in[3:2];
            if (w_cfWrite)         r_cfIdx <= (r_cfIdx == CF_LAST) ? '0 : r_cfIdx + ONE_CF;
            else if (w_startFrame) r_cfIdx <= '0;
        end
    end

    // Position tracking: the window centre only starts moving once D pushes have gone by.
    always_ff @(posedge clk or posedge reset_in) begin
        if (reset_in) begin
            r_inRow    <= '0;
            r_inCol    <= '0;
            r_cRow     <= '0;
            r_cCol     <= '0;
            r_pushCnt  <= '0;
            r_flushCnt <= '0;
        end else begin
            if (w_lastPush) begin
                r_cRow    <= '0;
                r_cCol    <= '0;
                r_pushCnt <= '0;
            end else if (w_win) begin
                if (w_cColEnd) begin
                    r_cCol <= '0;
                    r_cRow <= r_cRow + ONE_C;
                end else begin
                    r_cCol <= r_cCol + ONE_C;
                end
            end else if (w_push) begin
                r_pushCnt <= r_pushCnt + ONE_F;
            end
            if (w_pixel) begin
                if (w_lastPixel) begin
                    r_inCol <= '0;
                    r_inRow <= '0;
                end else if (w_inColEnd) begin
                    r_inCol <= '0;
                    r_inRow <= r_inRow + ONE_C;
                end else begin
                    r_inCol <= r_inCol + ONE_C;
                end
            end
            if (w_lastPixel)        r_flushCnt <= w_dist;
            else if (w_flushPush)   r_flushCnt <= r_flushCnt - ONE_F;
        end
    end
endmodule
